// File: rtl/nvram_autosave_sched.sv
// Autosave scheduler for the four NVRAM backup images.
// Each image becomes dirty on an SRAM write strobe. It becomes eligible for a
// save after a write-free idle period, or at once when the OSD asks for a save.
// One image at a time is handed to the backup engine as a single-cycle request.
// The scheduler then waits for the engine to go busy and to finish again.
module nvram_autosave_sched #(
    parameter logic [23:0] IDLE_CYCLES = 24'd3_000_000,
    parameter logic [15:0] ACK_TIMEOUT = 16'd4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] img_mounted,
    input  logic       img_readonly,
    input  logic [3:0] sram_we,
    input  logic [3:0] manual_save,
    input  logic       save_busy,
    output logic [3:0] save_req,
    output logic [3:0] pending,
    output logic       error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    // Scheduler state
    state_e           state_q;
    logic [1:0]       sel_q;
    logic [1:0]       rr_q;
    logic [15:0]      ack_cnt_q;
    logic [3:0]       save_req_q;
    logic             error_q;

    // Per-image tracking
    logic [3:0]       dirty_q, dirty_d;
    logic [3:0]       force_q, force_d;
    logic [3:0]       ro_q, ro_d;
    logic [3:0][23:0] timer_q, timer_d;

    // Arbitration
    logic [3:0]       elig;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             issue_go;
    logic             timeout_hit;

    // An image may be saved when it is writable and either forced by the OSD
    // or (with autosave on) dirty and idle for the full quiet period.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = ~ro_q[i] & (force_q[i] |
                      (enable & dirty_q[i] & (timer_q[i] == IDLE_CYCLES)));
        end
    end

    // Round-robin pick: scan upward from rr_q with wrap. The scan runs
    // backwards so the last match written is the first one in rr order.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front;
        // a path that leaves one unassigned would infer a latch.
        pick_valid = 1'b0;
        pick_idx   = rr_q;
        for (int k = 3; k >= 0; k--) begin
            if (elig[rr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_q + 2'(k);
            end
        end
    end

    // A request is launched on the edge that leaves IDLE; the timeout fires on
    // the last waiting cycle of WAIT_BUSY if the engine never went busy.
    assign issue_go    = (state_q == ST_IDLE) && pick_valid;
    assign timeout_hit = (state_q == ST_WAIT_BUSY) && !save_busy &&
                         (ack_cnt_q == ACK_TIMEOUT - 16'd1);

    // Per-image next state: mount beats everything, a write beats the clear
    // done by an issue, and a timed-out image is marked dirty again.
    always_comb begin
        dirty_d = dirty_q;
        force_d = force_q;
        ro_d    = ro_q;
        timer_d = timer_q;
        for (int i = 0; i < 4; i++) begin
            if (img_mounted[i]) begin
                dirty_d[i] = 1'b0;
                timer_d[i] = '0;
                ro_d[i]    = img_readonly;
                force_d[i] = 1'b0;
            end else begin
                if (sram_we[i]) begin
                    dirty_d[i] = 1'b1;
                    timer_d[i] = '0;
                end else if (issue_go && (pick_idx == 2'(i))) begin
                    dirty_d[i] = 1'b0;
                    timer_d[i] = '0;
                end else if (timeout_hit && (sel_q == 2'(i)) && !dirty_q[i]) begin
                    dirty_d[i] = 1'b1;
                end else if (dirty_q[i] && (timer_q[i] < IDLE_CYCLES)) begin
                    timer_d[i] = timer_q[i] + 24'd1;
                end

                if (manual_save[i]) begin
                    force_d[i] = 1'b1;
                end else if (issue_go && (pick_idx == 2'(i))) begin
                    force_d[i] = 1'b0;
                end
            end
        end
    end

    // Per-image registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the four idle timers are plain flops, not a RAM, so they are
        // reset with everything else and no image can start half-way idle.
        if (!reset_n) begin
            dirty_q <= '0;
            force_q <= '0;
            ro_q    <= '0;
            timer_q <= '0;
        end else begin
            dirty_q <= dirty_d;
            force_q <= force_d;
            ro_q    <= ro_d;
            timer_q <= timer_d;
        end
    end

    // Request sequencer with registered save_req and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_q       <= '0;
            ack_cnt_q  <= '0;
            save_req_q <= '0;
            error_q    <= 1'b0;
        end else begin
            save_req_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        sel_q      <= pick_idx;
                        rr_q       <= pick_idx + 2'd1;
                        save_req_q <= 4'b0001 << pick_idx;
                        ack_cnt_q  <= '0;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ack_cnt_q <= ack_cnt_q + 16'd1;
                    state_q   <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (save_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 16'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!save_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign save_req = save_req_q;
    assign pending  = dirty_q;
    assign error    = error_q;

endmodule

// File: tb/tb_nvram_autosave_sched.sv
// Bench for nvram_autosave_sched with a short idle period and ack timeout.
// A timestamp-based reference model checks every cycle; directed sequences
// and a vector table pin down latency, ordering and timeout corner cases.
module tb_nvram_autosave_sched;

    localparam logic [23:0] IDLE   = 24'd100;
    localparam logic [15:0] ACKT   = 16'd16;
    localparam int          IDLE_I = 100;
    localparam int          ACK_I  = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] img_mounted = '0;
    logic       img_readonly = 1'b0;
    logic [3:0] sram_we = '0;
    logic [3:0] manual_save = '0;
    logic       save_busy = 1'b0;
    logic [3:0] save_req;
    logic [3:0] pending;
    logic       error;

    int checks = 0;
    int failures = 0;

    nvram_autosave_sched #(.IDLE_CYCLES(IDLE), .ACK_TIMEOUT(ACKT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .sram_we      (sram_we),
        .manual_save  (manual_save),
        .save_busy    (save_busy),
        .save_req     (save_req),
        .pending      (pending),
        .error        (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: dirty images remember the edge of their last write;
    // the engine is either free (owner < 0) or owned by one image.
    int         m_now = 0;
    bit         m_dirty[4];
    bit         m_force[4];
    bit         m_ro[4];
    int         m_stamp[4];
    int         m_owner, m_issue, m_rr;
    bit         m_acked, m_err;
    logic [3:0] m_req;

    // Engine responder
    bit eng_auto = 0;
    bit eng_len_rand = 0;
    int eng_drop_pct = 0;
    int eng_cnt = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_dirty[i] = 0; m_force[i] = 0; m_ro[i] = 0; m_stamp[i] = 0;
        end
        m_owner = -1; m_issue = 0; m_rr = 0; m_acked = 0; m_err = 0; m_req = '0;
    endtask

    task automatic model_edge();
        bit el[4];
        int pick;
        int to_img;
        for (int i = 0; i < 4; i++)
            el[i] = !m_ro[i] && (m_force[i] ||
                    (enable && m_dirty[i] && (m_now - m_stamp[i] >= IDLE_I)));
        m_now++;
        pick = -1;
        to_img = -1;
        m_req = '0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++)
                if (pick < 0 && el[(m_rr + k) % 4]) pick = (m_rr + k) % 4;
            if (pick >= 0) begin
                m_owner = pick; m_issue = m_now; m_acked = 0;
                m_rr = (pick + 1) % 4;
                m_req[pick] = 1'b1;
            end
        end else if (m_now >= m_issue + 2) begin
            if (!m_acked) begin
                if (save_busy) m_acked = 1;
                else if (m_now - m_issue == ACK_I) begin
                    m_err = 1; to_img = m_owner; m_owner = -1;
                end
            end else if (!save_busy) begin
                m_owner = -1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pick == i) begin m_dirty[i] = 0; m_force[i] = 0; end
            if (to_img == i && !m_dirty[i]) begin m_dirty[i] = 1; m_stamp[i] = m_now; end
            if (sram_we[i]) begin m_dirty[i] = 1; m_stamp[i] = m_now; end
            if (manual_save[i]) m_force[i] = 1;
            if (img_mounted[i]) begin
                m_dirty[i] = 0; m_force[i] = 0; m_ro[i] = img_readonly;
            end
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, m_now, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later,
    // then the engine reacts to what it saw.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("save_req", save_req, m_req);
        check("pending", pending, {m_dirty[3], m_dirty[2], m_dirty[1], m_dirty[0]});
        check("error", {3'b000, error}, {3'b000, m_err});
        if (eng_auto) begin
            if (eng_cnt > 0) eng_cnt--;
            if (save_req != 4'b0000 && $urandom_range(99) >= eng_drop_pct)
                eng_cnt = eng_len_rand ? $urandom_range(6, 2) : 20;
            save_busy = (eng_cnt != 0);
        end
    endtask

    task automatic cyc(input logic [3:0] we_v, input logic [3:0] ms_v,
                       input logic [3:0] mnt_v, input logic ro_v);
        sram_we = we_v; manual_save = ms_v; img_mounted = mnt_v; img_readonly = ro_v;
        step();
        sram_we = '0; manual_save = '0; img_mounted = '0; img_readonly = 1'b0;
    endtask

    task automatic wait_req(input int bound, output int edge_o, output logic [3:0] val_o);
        edge_o = -1;
        val_o = '0;
        for (int n = 0; n < bound; n++) begin
            step();
            if (save_req != 4'b0000) begin
                edge_o = m_now; val_o = save_req;
                break;
            end
        end
        checks++;
        if (edge_o < 0) begin
            failures++;
            $display("FAIL wait_req: no save_req within %0d cycles", bound);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sram_we = '0; manual_save = '0; img_mounted = '0; img_readonly = 1'b0;
        save_busy = 1'b0; eng_cnt = 0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] we, ms, mnt;
        logic       ro, en, busy;
        logic [3:0] x_req, x_pend;
        logic       x_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int         e, t, last, w, hits, to_edge, iss_edge;
        logic [3:0] v;

        // {we, ms, mnt, ro, en, busy, expected req, expected pending, expected error}
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        tbl[2]  = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0010, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};

        // Reset state
        do_reset();
        #1;
        check("reset_req", save_req, 4'b0000);
        check("reset_pending", pending, 4'b0000);
        check("reset_error", {3'b000, error}, 4'b0000);

        // Vector table: manual save, readonly image, forced save beside a write
        eng_auto = 0;
        iss_edge = 0;
        for (int r = 0; r < 13; r++) begin
            enable = tbl[r].en;
            save_busy = tbl[r].busy;
            cyc(tbl[r].we, tbl[r].ms, tbl[r].mnt, tbl[r].ro);
            check($sformatf("tbl%0d_req", r), save_req, tbl[r].x_req);
            check($sformatf("tbl%0d_pend", r), pending, tbl[r].x_pend);
            check($sformatf("tbl%0d_err", r), {3'b000, error}, {3'b000, tbl[r].x_err});
            if (r == 11) iss_edge = m_now;
        end

        // Ack timeout: busy never rises after the image-0 request
        save_busy = 1'b0;
        to_edge = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (error) begin to_edge = m_now; break; end
        end
        check_int("timeout_edge", to_edge, iss_edge + ACK_I);
        check("timeout_pending", pending, 4'b0011);

        // Timed-out image reissues after a fresh idle period
        cyc(4'b0000, 4'b0000, 4'b0010, 1'b0);
        enable = 1'b1;
        eng_auto = 1; eng_len_rand = 0; eng_drop_pct = 0;
        wait_req(200, e, v);
        check_int("reissue_edge", e, to_edge + IDLE_I + 1);
        check("reissue_val", v, 4'b0001);

        // Asynchronous reset in the middle of WAIT_DONE
        repeat (5) step();
        cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
        check("pre_reset_pending", pending, 4'b0100);
        check("pre_reset_error", {3'b000, error}, 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_req", save_req, 4'b0000);
        check("async_reset_pending", pending, 4'b0000);
        check("async_reset_error", {3'b000, error}, 4'b0000);
        do_reset();

        // Single write: pulse exactly IDLE+1 edges later, pending drops with it
        enable = 1'b1;
        cyc(4'b0010, 4'b0000, 4'b0000, 1'b0);
        t = m_now;
        wait_req(200, e, v);
        check_int("single_edge", e, t + IDLE_I + 1);
        check("single_val", v, 4'b0010);
        check("single_pending", pending, 4'b0000);
        hits = 0;
        repeat (25) begin step(); if (save_req != 4'b0000) hits++; end
        check_int("single_quiet", hits, 0);

        // Write burst every 50 cycles holds off the save
        do_reset();
        enable = 1'b1;
        hits = 0;
        last = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
            last = m_now;
            repeat (49) begin step(); if (save_req != 4'b0000) hits++; end
        end
        check_int("burst_no_req", hits, 0);
        wait_req(200, e, v);
        check_int("burst_edge", e, last + IDLE_I + 1);
        check("burst_val", v, 4'b0100);

        // Three images eligible together: round-robin order, then wrap to 0
        do_reset();
        enable = 1'b1;
        cyc(4'b1101, 4'b0000, 4'b0000, 1'b0);
        t = m_now;
        wait_req(200, e, v);
        check_int("rr_first_edge", e, t + IDLE_I + 1);
        check("rr_first", v, 4'b0001);
        wait_req(100, e, v);
        check("rr_second", v, 4'b0100);
        wait_req(100, e, v);
        check("rr_third", v, 4'b1000);
        repeat (30) step();
        cyc(4'b1111, 4'b0000, 4'b0000, 1'b0);
        wait_req(200, e, v);
        check("rr_wrap", v, 4'b0001);

        // Manual save with autosave off, then a readonly image never saves
        do_reset();
        enable = 1'b0;
        cyc(4'b0000, 4'b1000, 4'b0000, 1'b0);
        step();
        check("manual_next_cycle", save_req, 4'b1000);
        repeat (30) step();
        cyc(4'b0000, 4'b0000, 4'b1000, 1'b1);
        cyc(4'b0000, 4'b1000, 4'b0000, 1'b0);
        hits = 0;
        repeat (50) begin step(); if (save_req != 4'b0000) hits++; end
        check_int("readonly_no_req", hits, 0);

        // Write to the image being saved during WAIT_DONE
        do_reset();
        enable = 1'b1;
        cyc(4'b0010, 4'b0000, 4'b0000, 1'b0);
        wait_req(200, e, v);
        repeat (5) step();
        cyc(4'b0010, 4'b0000, 4'b0000, 1'b0);
        w = m_now;
        repeat (20) step();
        check("rewrite_pending", pending, 4'b0010);
        wait_req(200, e, v);
        check_int("rewrite_edge", e, w + IDLE_I + 1);
        check("rewrite_val", v, 4'b0010);

        // Randomized traffic against the reference model
        do_reset();
        enable = 1'b1;
        eng_len_rand = 1;
        eng_drop_pct = 10;
        for (int n = 0; n < 5000; n++) begin
            for (int i = 0; i < 4; i++) begin
                sram_we[i]     = ($urandom_range(255) == 0);
                manual_save[i] = ($urandom_range(299) == 0);
                img_mounted[i] = ($urandom_range(599) == 0);
            end
            img_readonly = ($urandom_range(3) == 0);
            if ($urandom_range(499) == 0) enable = ~enable;
            step();
            sram_we = '0; manual_save = '0; img_mounted = '0; img_readonly = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
